// File: rtl/mul_pkg.sv
// Shared constants and state encoding for the approximate-multiplier error monitor.
package mul_pkg;

    localparam int unsigned MAC_IN_WIDTH_DEF = 9;
    localparam int unsigned CNT_WIDTH_DEF    = 16;
    localparam int unsigned ACC_WIDTH_DEF    = 32;
    localparam int unsigned DRAIN_CYCLES     = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/mul_abs_err.sv
// Two-stage pipeline: register operands/result, then the absolute error
// between the result under test and the exact signed product.
module mul_abs_err
    import mul_pkg::*;
#(
    parameter int unsigned MAC_IN_WIDTH = MAC_IN_WIDTH_DEF
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            valid_i,
    input  logic signed [MAC_IN_WIDTH-1:0]  a_i,
    input  logic signed [MAC_IN_WIDTH-1:0]  b_i,
    input  logic signed [2*MAC_IN_WIDTH-1:0] res_i,
    output logic                            valid_o,
    output logic [2*MAC_IN_WIDTH-1:0]       abs_err_o
);

    localparam int unsigned PW = 2 * MAC_IN_WIDTH;
    localparam int unsigned EW = PW + 1;

    logic                           r_s1_valid;
    logic signed [MAC_IN_WIDTH-1:0] r_a;
    logic signed [MAC_IN_WIDTH-1:0] r_b;
    logic signed [PW-1:0]           r_res;
    logic                           r_s2_valid;
    logic [PW-1:0]                  r_abs;

    logic signed [PW-1:0] w_a_ext;
    logic signed [PW-1:0] w_b_ext;
    logic signed [PW-1:0] w_exact;
    logic [EW-1:0]        w_err;
    logic [EW-1:0]        w_err_neg;
    logic [PW-1:0]        w_abs;

    // Product of sign-extended operands; the true product always fits in PW bits.
    assign w_a_ext   = {{MAC_IN_WIDTH{r_a[MAC_IN_WIDTH-1]}}, r_a};
    assign w_b_ext   = {{MAC_IN_WIDTH{r_b[MAC_IN_WIDTH-1]}}, r_b};
    assign w_exact   = w_a_ext * w_b_ext;
    assign w_err     = {r_res[PW-1], r_res} - {w_exact[PW-1], w_exact};
    assign w_err_neg = EW'(0) - w_err;
    assign w_abs     = w_err[EW-1] ? w_err_neg[PW-1:0] : w_err[PW-1:0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s1_valid <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_res      <= '0;
            r_s2_valid <= 1'b0;
            r_abs      <= '0;
        end else begin
            r_s1_valid <= valid_i;
            r_s2_valid <= r_s1_valid;
            if (valid_i) begin
                r_a   <= a_i;
                r_b   <= b_i;
                r_res <= res_i;
            end
            if (r_s1_valid) begin
                r_abs <= w_abs;
            end
        end
    end

    assign valid_o   = r_s2_valid;
    assign abs_err_o = r_abs;

endmodule

// File: rtl/mul_err_monitor.sv
// Windowed error statistics (count, saturating sum, max of |res - a*b|)
// for an approximate multiplier under test.
module mul_err_monitor
    import mul_pkg::*;
#(
    parameter int unsigned MAC_IN_WIDTH = MAC_IN_WIDTH_DEF,
    parameter int unsigned CNT_WIDTH    = CNT_WIDTH_DEF,
    parameter int unsigned ACC_WIDTH    = ACC_WIDTH_DEF
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             start_i,
    input  logic [CNT_WIDTH-1:0]             win_len_i,
    input  logic                             valid_i,
    output logic                             ready_o,
    input  logic signed [MAC_IN_WIDTH-1:0]   a_i,
    input  logic signed [MAC_IN_WIDTH-1:0]   b_i,
    input  logic signed [2*MAC_IN_WIDTH-1:0] res_i,
    output logic                             busy_o,
    output logic                             done_o,
    output logic [CNT_WIDTH-1:0]             err_cnt_o,
    output logic [ACC_WIDTH-1:0]             sum_abs_err_o,
    output logic [2*MAC_IN_WIDTH-1:0]        max_abs_err_o
);

    localparam int unsigned PW         = 2 * MAC_IN_WIDTH;
    localparam logic [1:0]  DRAIN_LAST = 2'(DRAIN_CYCLES - 1);

    state_e               r_state;
    logic [CNT_WIDTH-1:0] r_len;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [1:0]           r_drain;
    logic                 r_ready;
    logic                 r_busy;
    logic                 r_done;
    logic [CNT_WIDTH-1:0] r_err_cnt;
    logic [ACC_WIDTH-1:0] r_sum;
    logic [PW-1:0]        r_max;

    logic                 w_accept;
    logic                 w_start;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;
    logic                 w_s2_valid;
    logic [PW-1:0]        w_s2_abs;
    logic [ACC_WIDTH:0]   w_sum_ext;

    assign w_accept  = valid_i && r_ready;
    assign w_start   = start_i && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
    assign w_sum_ext = {1'b0, r_sum} + {{(ACC_WIDTH + 1 - PW){1'b0}}, w_s2_abs};

    mul_abs_err #(
        .MAC_IN_WIDTH(MAC_IN_WIDTH)
    ) u_abs_err (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .valid_i  (w_accept),
        .a_i      (a_i),
        .b_i      (b_i),
        .res_i    (res_i),
        .valid_o  (w_s2_valid),
        .abs_err_o(w_s2_abs)
    );

    // Window control with registered handshake/status outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_len   <= '0;
            r_cnt   <= '0;
            r_drain <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        r_len   <= win_len_i;
                        r_cnt   <= '0;
                        r_drain <= '0;
                        if (win_len_i == '0) begin
                            r_state <= ST_DONE;
                            r_ready <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_RUN;
                            r_ready <= 1'b1;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_accept) begin
                        r_cnt <= w_cnt_nxt;
                        if (w_cnt_nxt == r_len) begin
                            r_state <= ST_DRAIN;
                            r_ready <= 1'b0;
                            r_drain <= '0;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Last sample reaches the statistics before DONE is raised.
                    if (r_drain == DRAIN_LAST) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_drain <= r_drain + 2'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Saturating statistics; cleared on an accepted start.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err_cnt <= '0;
            r_sum     <= '0;
            r_max     <= '0;
        end else if (w_start) begin
            r_err_cnt <= '0;
            r_sum     <= '0;
            r_max     <= '0;
        end else if (w_s2_valid) begin
            if ((w_s2_abs != '0) && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + CNT_WIDTH'(1);
            end
            r_sum <= w_sum_ext[ACC_WIDTH] ? '1 : w_sum_ext[ACC_WIDTH-1:0];
            if (w_s2_abs > r_max) begin
                r_max <= w_s2_abs;
            end
        end
    end

    assign ready_o       = r_ready;
    assign busy_o        = r_busy;
    assign done_o        = r_done;
    assign err_cnt_o     = r_err_cnt;
    assign sum_abs_err_o = r_sum;
    assign max_abs_err_o = r_max;

endmodule

// File: tb/tb_mul_err_monitor.sv
// Randomized bench for mul_err_monitor: two instances (32-bit and 18-bit
// accumulator) share stimulus and are checked against an arithmetic model.
module tb_mul_err_monitor;

    localparam int unsigned W   = 9;
    localparam int unsigned CW  = 16;
    localparam int unsigned AW  = 32;
    localparam int unsigned AWB = 18;
    localparam int unsigned PW  = 2 * W;

    logic                 clk_i = 1'b0;
    logic                 rst_ni;
    logic                 start_i;
    logic [CW-1:0]        win_len_i;
    logic                 valid_i;
    logic signed [W-1:0]  a_i;
    logic signed [W-1:0]  b_i;
    logic signed [PW-1:0] res_i;

    logic          ready_o, busy_o, done_o;
    logic [CW-1:0] err_cnt_o;
    logic [AW-1:0] sum_abs_err_o;
    logic [PW-1:0] max_abs_err_o;

    logic           ready_b, busy_b, done_b;
    logic [CW-1:0]  err_cnt_b;
    logic [AWB-1:0] sum_b;
    logic [PW-1:0]  max_b;

    int n_chk  = 0;
    int n_pass = 0;

    int q_a[$];
    int q_b[$];
    int q_r[$];

    always #5 clk_i = ~clk_i;

    mul_err_monitor #(.MAC_IN_WIDTH(W), .CNT_WIDTH(CW), .ACC_WIDTH(AW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .win_len_i(win_len_i),
        .valid_i(valid_i), .ready_o(ready_o), .a_i(a_i), .b_i(b_i), .res_i(res_i),
        .busy_o(busy_o), .done_o(done_o), .err_cnt_o(err_cnt_o),
        .sum_abs_err_o(sum_abs_err_o), .max_abs_err_o(max_abs_err_o)
    );

    mul_err_monitor #(.MAC_IN_WIDTH(W), .CNT_WIDTH(CW), .ACC_WIDTH(AWB)) dut_b (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .win_len_i(win_len_i),
        .valid_i(valid_i), .ready_o(ready_b), .a_i(a_i), .b_i(b_i), .res_i(res_i),
        .busy_o(busy_b), .done_o(done_b), .err_cnt_o(err_cnt_b),
        .sum_abs_err_o(sum_b), .max_abs_err_o(max_b)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic push(input int a, input int b, input int r);
        q_a.push_back(a);
        q_b.push_back(b);
        q_r.push_back(r);
    endtask

    task automatic clear_q();
        q_a.delete();
        q_b.delete();
        q_r.delete();
    endtask

    // Random sample: exact, slightly off, or an arbitrary result.
    task automatic push_rand();
        int a, b, r, mode;
        a    = int'($urandom_range(0, 511)) - 256;
        b    = int'($urandom_range(0, 511)) - 256;
        mode = int'($urandom_range(0, 2));
        if (mode == 0)      r = a * b;
        else if (mode == 1) r = a * b + int'($urandom_range(0, 40)) - 20;
        else                r = int'($urandom_range(0, 262143)) - 131072;
        push(a, b, r);
    endtask

    // Reference statistics over the first len queued samples.
    task automatic check_stats(input string tag, input int len);
        longint c, s, m, d, s32, s18;
        c = 0; s = 0; m = 0;
        for (int i = 0; i < len; i++) begin
            d = longint'(q_r[i]) - longint'(q_a[i]) * longint'(q_b[i]);
            if (d < 0) d = -d;
            if (d != 0) c++;
            s += d;
            if (d > m) m = d;
        end
        s32 = (s > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : s;
        s18 = (s > 64'h3_FFFF) ? 64'h3_FFFF : s;
        check({tag, "_errcnt"}, err_cnt_o, c);
        check({tag, "_sum"}, sum_abs_err_o, s32);
        check({tag, "_max"}, max_abs_err_o, m);
        check({tag, "_sum18"}, sum_b, s18);
        check({tag, "_max18"}, max_b, m);
        check({tag, "_errcnt18"}, err_cnt_b, c);
    endtask

    task automatic drive_sample(input int idx);
        int k;
        k = (idx < q_a.size()) ? idx : 0;
        a_i   = W'(q_a[k]);
        b_i   = W'(q_b[k]);
        res_i = PW'(q_r[k]);
    endtask

    // One full window: start, feed samples, wait for done, compare.
    task automatic run_window(input string tag, input int len, input bit rand_valid);
        int acc, cyc, since;
        bit took, v;
        @(posedge clk_i); #1;
        start_i   = 1'b1;
        win_len_i = CW'(len);
        valid_i   = 1'b0;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        if (len == 0) begin
            check({tag, "_done"}, done_o, 1);
            check({tag, "_ready"}, ready_o, 0);
            check_stats(tag, 0);
            @(posedge clk_i); #1;
            check({tag, "_ready2"}, ready_o, 0);
            check({tag, "_busy"}, busy_o, 0);
            return;
        end
        check({tag, "_ready_run"}, ready_o, 1);
        check({tag, "_busy_run"}, busy_o, 1);
        acc = 0; cyc = 0; since = 0;
        while (!done_o && cyc < 400) begin
            v = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            valid_i = v;
            drive_sample(acc);
            took = v && ready_o;
            @(posedge clk_i); #1;
            cyc++;
            if (took) begin
                acc++;
                if (acc == len) begin
                    since = 0;
                    check({tag, "_ready_after_last"}, ready_o, 0);
                end
            end else if (acc >= len) begin
                since++;
            end
        end
        valid_i = 1'b0;
        check({tag, "_accepts"}, acc, len);
        check({tag, "_done_lat"}, since, 3);
        check({tag, "_done"}, done_o, 1);
        check({tag, "_busy_done"}, busy_o, 0);
        check({tag, "_done18"}, done_b, 1);
        check_stats(tag, len);
        repeat (3) @(posedge clk_i);
        #1;
        check_stats({tag, "_hold"}, len);
    endtask

    initial begin
        int n;
        rst_ni = 1'b0; start_i = 1'b0; win_len_i = '0; valid_i = 1'b0;
        a_i = '0; b_i = '0; res_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_ready", ready_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check_stats("rst", 0);
        rst_ni = 1'b1;

        clear_q();
        for (int i = 0; i < 4; i++) push(5, -3, -15);
        run_window("exact4", 4, 1'b0);

        clear_q();
        push(3, 4, 10); push(2, 2, 11); push(-1, 1, 2);
        run_window("err3", 3, 1'b0);

        clear_q();
        run_window("zero", 0, 1'b0);

        clear_q();
        for (int i = 0; i < 3; i++) push(0, 0, 131071);
        run_window("sat", 3, 1'b0);

        clear_q();
        for (int i = 0; i < 10; i++) push_rand();
        run_window("rand10", 10, 1'b1);

        clear_q();
        push(-256, -256, 65536); push(-256, 255, -131072); push(255, 255, 131071);
        run_window("extreme", 3, 1'b1);

        for (int t = 0; t < 4; t++) begin
            int len;
            clear_q();
            len = int'($urandom_range(1, 12));
            for (int i = 0; i < len; i++) push_rand();
            run_window($sformatf("rwin%0d", t), len, 1'b1);
        end

        // Reset mid-window after two erroneous samples.
        clear_q();
        for (int i = 0; i < 5; i++) push(1, 1, 100);
        @(posedge clk_i); #1;
        start_i = 1'b1; win_len_i = CW'(5);
        @(posedge clk_i); #1;
        start_i = 1'b0;
        n = 0;
        for (int c = 0; c < 20 && n < 2; c++) begin
            bit took;
            valid_i = 1'b1;
            drive_sample(n);
            took = ready_o;
            @(posedge clk_i); #1;
            if (took) n++;
        end
        valid_i = 1'b1;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        @(posedge clk_i); #1;
        check("prerst_errcnt", err_cnt_o, 2);
        #3 rst_ni = 1'b0;
        #1;
        check("midrst_ready", ready_o, 0);
        check("midrst_busy", busy_o, 0);
        check("midrst_done", done_o, 0);
        check_stats("midrst", 0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        repeat (4) @(posedge clk_i);
        #1;
        check_stats("postrst", 0);
        check("postrst_busy", busy_o, 0);
        clear_q();
        push(2, 3, 6);
        run_window("after_rst", 1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
